// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter and scoreboard for the single-write-port register file.
// Round-robins the ALU and load unit onto the write port and tracks outstanding writes per register.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 3,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src0_valid,
  input  logic [AW-1:0]     src0_reg,
  input  logic [DATA_W-1:0] src0_data,
  output logic              src0_ready,
  input  logic              src1_valid,
  input  logic [AW-1:0]     src1_reg,
  input  logic [DATA_W-1:0] src1_data,
  output logic              src1_ready,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_reg,
  output logic              iss_ready,
  input  logic [AW-1:0]     rd1_reg,
  input  logic [AW-1:0]     rd2_reg,
  output logic              rd1_busy,
  output logic              rd2_busy,
  output logic              wr_en,
  output logic [AW-1:0]     wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic              sb_err
);

  localparam int unsigned NREG = 2 ** AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic prio;
  logic prio_nxt;
  logic gnt0;
  logic gnt1;

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic             iss_fire;
  logic             underflow;

  // Priority pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else begin
      prio <= prio_nxt;
    end
  end

  // Pointer moves to the loser after a grant, holds otherwise
  always_comb begin
    prio_nxt = prio;
    if (gnt0) begin
      prio_nxt = 1'b1;
    end else if (gnt1) begin
      prio_nxt = 1'b0;
    end
  end

  // Grant decode: depends only on the valids and the pointer
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (src0_valid && src1_valid) begin
      gnt0 = !prio;
      gnt1 = prio;
    end else begin
      gnt0 = src0_valid;
      gnt1 = src1_valid;
    end
  end

  assign src0_ready = gnt0;
  assign src1_ready = gnt1;

  // Registered write port; address and data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= gnt0 | gnt1;
      if (gnt0) begin
        wr_reg  <= src0_reg;
        wr_data <= src0_data;
      end else if (gnt1) begin
        wr_reg  <= src1_reg;
        wr_data <= src1_data;
      end
    end
  end

  assign iss_ready = (cnt[iss_reg] != CNT_MAX);
  assign iss_fire  = iss_en && iss_ready;
  assign rd1_busy  = (cnt[rd1_reg] != '0);
  assign rd2_busy  = (cnt[rd2_reg] != '0);
  assign underflow = wr_en && (cnt[wr_reg] == '0);

  assign inc_vec = iss_fire ? (NREG'(1) << iss_reg) : '0;
  assign dec_vec = wr_en    ? (NREG'(1) << wr_reg)  : '0;

  // Per-register count update; a matching issue and commit cancel out
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
      end
    end
  end

  // Scoreboard state and sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      sb_err <= sb_err | underflow;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter: arbitration, writeback latency and scoreboard.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        src0_valid;
  logic [2:0]  src0_reg;
  logic [31:0] src0_data;
  logic        src0_ready;
  logic        src1_valid;
  logic [2:0]  src1_reg;
  logic [31:0] src1_data;
  logic        src1_ready;
  logic        iss_en;
  logic [2:0]  iss_reg;
  logic        iss_ready;
  logic [2:0]  rd1_reg;
  logic [2:0]  rd2_reg;
  logic        rd1_busy;
  logic        rd2_busy;
  logic        wr_en;
  logic [2:0]  wr_reg;
  logic [31:0] wr_data;
  logic        sb_err;

  int n_chk;
  int n_fail;

  rf_wb_arbiter #(.DATA_W(32), .AW(3), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .src0_valid (src0_valid),
    .src0_reg   (src0_reg),
    .src0_data  (src0_data),
    .src0_ready (src0_ready),
    .src1_valid (src1_valid),
    .src1_reg   (src1_reg),
    .src1_data  (src1_data),
    .src1_ready (src1_ready),
    .iss_en     (iss_en),
    .iss_reg    (iss_reg),
    .iss_ready  (iss_ready),
    .rd1_reg    (rd1_reg),
    .rd2_reg    (rd2_reg),
    .rd1_busy   (rd1_busy),
    .rd2_busy   (rd2_busy),
    .wr_en      (wr_en),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .sb_err     (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] r);
    @(negedge clk);
    iss_en  = 1'b1;
    iss_reg = r;
    #1 chk("issue_ready", 32'(iss_ready), 32'd1);
    @(negedge clk);
    iss_en = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    src0_valid = 1'b0; src0_reg = '0; src0_data = '0;
    src1_valid = 1'b0; src1_reg = '0; src1_data = '0;
    iss_en = 1'b0; iss_reg = '0; rd1_reg = '0; rd2_reg = '0;

    // Reset state; readies follow the valids with prio = 0
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_reg", 32'(wr_reg), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_sb_err", 32'(sb_err), 32'd0);
    chk("rst_iss_ready", 32'(iss_ready), 32'd1);
    chk("rst_rd1_busy", 32'(rd1_busy), 32'd0);
    src0_valid = 1'b1; src1_valid = 1'b1;
    #1 chk("rst_src0_ready", 32'(src0_ready), 32'd1);
    chk("rst_src1_ready", 32'(src1_ready), 32'd0);
    src0_valid = 1'b0; src1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Outstanding writes for the following commits
    issue(3'd1); issue(3'd1); issue(3'd2); issue(3'd2); issue(3'd5);

    // Both valid: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        src0_valid = 1'b1; src0_reg = 3'd1; src0_data = 32'h11;
        src1_valid = 1'b1; src1_reg = 3'd2; src1_data = 32'h22;
      end else begin
        chk("rr_wr_en", 32'(wr_en), 32'd1);
        chk("rr_wr_reg", 32'(wr_reg), (i % 2 == 1) ? 32'd1 : 32'd2);
        chk("rr_wr_data", wr_data, (i % 2 == 1) ? 32'h11 : 32'h22);
      end
      #1 chk("rr_src0_ready", 32'(src0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_src1_ready", 32'(src1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    chk("rr_last_wr_reg", 32'(wr_reg), 32'd2);
    src0_valid = 1'b0; src1_valid = 1'b0;
    @(negedge clk);
    chk("rr_idle_wr_en", 32'(wr_en), 32'd0);
    chk("rr_hold_wr_reg", 32'(wr_reg), 32'd2);

    // src0 only: one-cycle writeback latency
    @(negedge clk);
    src0_valid = 1'b1; src0_reg = 3'd5; src0_data = 32'hDEADBEEF;
    #1 chk("s0_src0_ready", 32'(src0_ready), 32'd1);
    chk("s0_src1_ready", 32'(src1_ready), 32'd0);
    @(negedge clk);
    chk("s0_wr_en", 32'(wr_en), 32'd1);
    chk("s0_wr_reg", 32'(wr_reg), 32'd5);
    chk("s0_wr_data", wr_data, 32'hDEADBEEF);
    src0_valid = 1'b0;
    @(negedge clk);
    chk("s0_wr_en_off", 32'(wr_en), 32'd0);
    rd1_reg = 3'd5;
    #1 chk("s0_rd1_busy", 32'(rd1_busy), 32'd0);

    // RAW busy on r3 clears after the load-unit commit
    issue(3'd3);
    rd1_reg = 3'd3;
    #1 chk("r3_busy_set", 32'(rd1_busy), 32'd1);
    src1_valid = 1'b1; src1_reg = 3'd3; src1_data = 32'h33;
    #1 chk("r3_src1_ready", 32'(src1_ready), 32'd1);
    @(negedge clk);
    chk("r3_wr_reg", 32'(wr_reg), 32'd3);
    chk("r3_busy_inflight", 32'(rd1_busy), 32'd1);
    src1_valid = 1'b0;
    @(negedge clk);
    chk("r3_busy_clear", 32'(rd1_busy), 32'd0);

    // Counter saturation on r4
    issue(3'd4); issue(3'd4); issue(3'd4);
    iss_reg = 3'd4;
    #1 chk("r4_full", 32'(iss_ready), 32'd0);
    iss_en = 1'b1;
    #1 chk("r4_full_req", 32'(iss_ready), 32'd0);
    @(negedge clk);
    iss_en = 1'b0;
    #1 chk("r4_ignored", 32'(iss_ready), 32'd0);
    rd2_reg = 3'd4;
    #1 chk("r4_rd2_busy", 32'(rd2_busy), 32'd1);
    src0_valid = 1'b1; src0_reg = 3'd4; src0_data = 32'h44;
    @(negedge clk);
    src0_valid = 1'b0;
    chk("r4_wr_reg", 32'(wr_reg), 32'd4);
    chk("r4_no_lookahead", 32'(iss_ready), 32'd0);
    @(negedge clk);
    chk("r4_ready_again", 32'(iss_ready), 32'd1);

    // Issue and commit to r6 in the same cycle
    issue(3'd6);
    rd2_reg = 3'd6;
    src0_valid = 1'b1; src0_reg = 3'd6; src0_data = 32'h66;
    @(negedge clk);
    src0_valid = 1'b0;
    chk("r6_wr_reg", 32'(wr_reg), 32'd6);
    iss_en = 1'b1; iss_reg = 3'd6;
    #1 chk("r6_iss_ready", 32'(iss_ready), 32'd1);
    chk("r6_busy_before", 32'(rd2_busy), 32'd1);
    @(negedge clk);
    iss_en = 1'b0;
    #1 chk("r6_busy_after", 32'(rd2_busy), 32'd1);
    chk("r6_no_err", 32'(sb_err), 32'd0);
    @(negedge clk);
    chk("r6_busy_held", 32'(rd2_busy), 32'd1);

    // Underflow on r0 sets sticky sb_err
    src0_valid = 1'b1; src0_reg = 3'd0; src0_data = 32'h0;
    @(negedge clk);
    src0_valid = 1'b0;
    chk("uf_wr_reg", 32'(wr_reg), 32'd0);
    chk("uf_err_before", 32'(sb_err), 32'd0);
    @(negedge clk);
    chk("uf_err_set", 32'(sb_err), 32'd1);
    rd1_reg = 3'd0;
    #1 chk("uf_r0_zero", 32'(rd1_busy), 32'd0);
    src1_valid = 1'b1; src1_reg = 3'd7; src1_data = 32'h77;
    @(negedge clk);
    src1_valid = 1'b0;
    chk("uf_inflight", 32'(wr_en), 32'd1);
    chk("uf_err_sticky", 32'(sb_err), 32'd1);
    rd1_reg = 3'd4;
    #1 chk("pre_rst_r4_busy", 32'(rd1_busy), 32'd1);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1 chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_sb_err", 32'(sb_err), 32'd0);
    chk("arst_rd1_busy", 32'(rd1_busy), 32'd0);
    chk("arst_rd2_busy", 32'(rd2_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    src0_valid = 1'b1; src0_reg = 3'd2; src0_data = 32'hA5;
    #1 chk("post_rst_ready", 32'(src0_ready), 32'd1);
    @(negedge clk);
    src0_valid = 1'b0;
    chk("post_rst_wr_en", 32'(wr_en), 32'd1);
    chk("post_rst_wr_data", wr_data, 32'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
